conv_sequencer: RTL and testbench

// Sequences the 3x3 convolution datapath (mem_controller processing port + ALU + kernel_ROM).
// Per accepted frame: walks every pixel in raster order on raddr_alu, then writes the ALU

---
 rtl/conv_sequencer.sv | 137 +++++++++++++
 tb/tb_conv_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer.sv
// Frame sequencer for the 3x3 convolution path: raster-walks the read port, then
// replays each index on the write port RD_LAT clocks later with its edge flag.
module conv_sequencer #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int AW     = 17,
    parameter int RD_LAT = 2
) (
    input  logic          CLK100MHZ,
    input  logic          rst_n,
    input  logic          start,
    input  logic          enable,
    input  logic [1:0]    kernel_sel_in,
    output logic [1:0]    kernel_sel,
    output logic [AW-1:0] raddr_alu,
    output logic [AW-1:0] waddr_alu,
    output logic          wen_alu,
    output logic          border,
    output logic          pass_thru,
    output logic          busy,
    output logic          done,
    output logic          overrun
);
    localparam int N  = IMG_W * IMG_H;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t  state_q, state_d;
    logic    issue;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic    is_edge;

    // Stage 0 is aligned with raddr_alu, stage RD_LAT with the write strobe.
    logic [RD_LAT:0]         vld_pipe_q;
    logic [RD_LAT:0]         edge_pipe_q;
    logic [RD_LAT:0][AW-1:0] idx_pipe_q;

    logic [1:0] ksel_q;
    logic       pt_q, busy_q, done_q, ovr_q;

    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: if (start && enable) begin
                state_d = RUN;
                issue   = 1'b1;
            end
            RUN: begin
                issue = 1'b1;
                if (cnt_q == LAST_IDX) state_d = DRAIN;
            end
            // Leave once the only valid entry left is the one being written now.
            DRAIN: if (~|vld_pipe_q[RD_LAT-1:0]) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        x_d   = x_q;
        y_d   = y_q;
        if (issue) begin
            if (cnt_q == LAST_IDX) begin
                cnt_d = '0;
                x_d   = '0;
                y_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
        end
    end

    assign is_edge = (x_q == '0) || (x_q == X_LAST) || (y_q == '0) || (y_q == Y_LAST);

    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            vld_pipe_q  <= '0;
            edge_pipe_q <= '0;
            idx_pipe_q  <= '0;
            ksel_q      <= 2'd0;
            pt_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            x_q   <= x_d;
            y_q   <= y_d;
            vld_pipe_q[0]  <= issue;
            edge_pipe_q[0] <= issue & is_edge;
            if (issue) idx_pipe_q[0] <= cnt_q;
            for (int s = 1; s <= RD_LAT; s++) begin
                vld_pipe_q[s]  <= vld_pipe_q[s-1];
                edge_pipe_q[s] <= edge_pipe_q[s-1];
                idx_pipe_q[s]  <= idx_pipe_q[s-1];
            end
            if (state_q == IDLE && state_d == RUN) ksel_q <= kernel_sel_in;
            pt_q   <= (state_d == IDLE) ? ~enable : 1'b0;
            busy_q <= (state_d == RUN) || (state_d == DRAIN);
            done_q <= (state_d == DONE);
            if (start && (state_q == RUN || state_q == DRAIN)) ovr_q <= 1'b1;
        end
    end

    assign kernel_sel = ksel_q;
    assign raddr_alu  = idx_pipe_q[0];
    assign waddr_alu  = idx_pipe_q[RD_LAT];
    assign wen_alu    = vld_pipe_q[RD_LAT];
    assign border     = edge_pipe_q[RD_LAT];
    assign pass_thru  = pt_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overrun    = ovr_q;
endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: frame-timing model checked every cycle plus literal expectations.
module tb_conv_sequencer;
    localparam int W = 8, H = 4, AW = 5, RL = 2, N = W * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, enable;
    logic [1:0] kernel_sel_in, kernel_sel;
    logic [AW-1:0] raddr_alu, waddr_alu;
    logic wen_alu, border, pass_thru, busy, done, overrun;

    conv_sequencer #(.IMG_W(W), .IMG_H(H), .AW(AW), .RD_LAT(RL)) dut (
        .CLK100MHZ(clk), .rst_n(rst_n), .start(start), .enable(enable),
        .kernel_sel_in(kernel_sel_in), .kernel_sel(kernel_sel),
        .raddr_alu(raddr_alu), .waddr_alu(waddr_alu), .wen_alu(wen_alu),
        .border(border), .pass_thru(pass_thru), .busy(busy), .done(done),
        .overrun(overrun)
    );

    int tests = 0, fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit pix_edge(input int i);
        int x, y;
        x = i % W;
        y = i / W;
        return (x == 0) || (x == W - 1) || (y == 0) || (y == H - 1);
    endfunction

    // Model: a frame accepted at edge s occupies cycles s+1 .. s+N+RL+1 (p = 1 .. N+RL+1).
    int ecnt = -1, s = 0, mq;
    bit have = 0, movr = 0, mpt = 1, chk_en = 0;
    bit [1:0] mk = 0;
    int wr_cnt = 0, brd_cnt = 0, done_p = -1, first_wen_p = -1;

    always @(posedge clk) begin
        ecnt++;
        if (!rst_n) begin
            have = 0; mk = 0; movr = 0; mpt = 1; chk_en = 1;
        end else begin
            mq = ecnt - s;
            if (start && (!have || mq >= N + RL + 2)) begin
                if (enable) begin
                    have = 1; s = ecnt; mk = kernel_sel_in;
                    wr_cnt = 0; brd_cnt = 0; done_p = -1; first_wen_p = -1;
                end
            end else if (start && have && mq >= 1 && mq <= N + RL) begin
                movr = 1;
            end
            mpt = ~enable;
        end
    end

    int p, e_raddr;
    bit e_wen, e_busy, e_done, e_pt;
    always @(negedge clk) begin
        if (chk_en) begin
            p = have ? ecnt + 1 - s : -1;
            if (have && p >= 1 && p <= N) e_raddr = p - 1;
            else if (have && p > N)       e_raddr = N - 1;
            else                          e_raddr = 0;
            e_wen  = have && p >= RL + 1 && p <= RL + N;
            e_busy = have && p >= 1 && p <= N + RL;
            e_done = have && p == N + RL + 1;
            e_pt   = (have && p >= 1 && p <= N + RL + 1) ? 1'b0 : mpt;
            chk("raddr", int'(raddr_alu), e_raddr);
            chk("wen", int'(wen_alu), int'(e_wen));
            if (e_wen) begin
                chk("waddr", int'(waddr_alu), p - RL - 1);
                chk("border", int'(border), int'(pix_edge(p - RL - 1)));
            end
            chk("busy", int'(busy), int'(e_busy));
            chk("done", int'(done), int'(e_done));
            chk("pass_thru", int'(pass_thru), int'(e_pt));
            chk("kernel_sel", int'(kernel_sel), int'(mk));
            chk("overrun", int'(overrun), int'(movr));
            if (wen_alu === 1'b1) begin
                wr_cnt++;
                if (border === 1'b1) brd_cnt++;
                if (first_wen_p < 0) first_wen_p = p;
            end
            if (done === 1'b1) done_p = p;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        rst_n = 0; start = 0; enable = 0; kernel_sel_in = 0;
        tick(2);
        chk("rst pass_thru", int'(pass_thru), 1);
        chk("rst wen", int'(wen_alu), 0);
        chk("rst raddr", int'(raddr_alu), 0);
        chk("rst border", int'(border), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst overrun", int'(overrun), 0);

        // Run 1: kernel 2 latched, request changes to 1 in cycle 10.
        rst_n = 1; enable = 1; kernel_sel_in = 2;
        tick(2);
        chk("idle pass_thru en", int'(pass_thru), 0);
        start = 1; tick(); start = 0;
        chk("r1 raddr cyc1", int'(raddr_alu), 0);
        tick(9); kernel_sel_in = 1;
        tick(35);
        chk("r1 writes", wr_cnt, 32);
        chk("r1 borders", brd_cnt, 20);
        chk("r1 first wen cyc", first_wen_p, 3);
        chk("r1 done cyc", done_p, 35);
        chk("r1 kernel", int'(kernel_sel), 2);
        chk("r1 raddr hold", int'(raddr_alu), 31);

        // Run 2: new kernel, start in cycle 20 (overrun), start during DONE ignored.
        start = 1; tick(); start = 0;
        chk("r2 kernel", int'(kernel_sel), 1);
        tick(19); start = 1; tick(); start = 0;
        tick(14); start = 1; tick(); start = 0;
        tick(5);
        chk("r2 overrun", int'(overrun), 1);
        chk("r2 writes", wr_cnt, 32);
        chk("r2 no restart", int'(busy), 0);

        // Run 3: enable dropped in cycle 5; then start with enable=0 is ignored.
        kernel_sel_in = 3;
        start = 1; tick(); start = 0;
        tick(4); enable = 0;
        tick(35);
        chk("r3 writes", wr_cnt, 32);
        chk("r3 pass_thru", int'(pass_thru), 1);
        start = 1; tick(); start = 0;
        tick(3);
        chk("r3 no run", int'(busy), 0);
        chk("r3 overrun sticky", int'(overrun), 1);

        // Run 4: reset in cycle 12 aborts, then a clean frame.
        enable = 1;
        start = 1; tick(); start = 0;
        tick(11); rst_n = 0; tick();
        chk("r4 abort wen", int'(wen_alu), 0);
        chk("r4 abort pass_thru", int'(pass_thru), 1);
        chk("r4 abort kernel", int'(kernel_sel), 0);
        chk("r4 abort overrun", int'(overrun), 0);
        chk("r4 abort raddr", int'(raddr_alu), 0);
        rst_n = 1; tick(2);
        start = 1; tick(); start = 0;
        tick(40);
        chk("r5 writes", wr_cnt, 32);
        chk("r5 borders", brd_cnt, 20);
        chk("r5 done cyc", done_p, 35);
        chk("r5 kernel", int'(kernel_sel), 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
